// File: rtl/vga_sync_monitor_pkg.sv
// VGA 640x480 timing constants and the monitor state encoding,
// shared by the monitor top and its testbench.
package vga_sync_monitor_pkg;

   localparam int unsigned VGA_CLK_PER_PIX = 4;
   localparam int unsigned VGA_H_TOTAL     = 800;
   localparam int unsigned VGA_H_SYNC      = 96;
   localparam int unsigned VGA_V_TOTAL     = 525;
   localparam int unsigned VGA_V_SYNC      = 2;
   localparam int unsigned VGA_LOCK_FRAMES = 2;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } mon_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus one history flop; rise_o/fall_o are one-cycle
// pulses derived from the synchronized level (idle level is high).
module sync_edge_detect (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic async_i,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign rise_o = sync_q & ~prev_q;
   assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/vga_sync_monitor.sv
// Measures incoming hSync/vSync timing against the parameters, locks after
// LOCK_FRAMES consecutive good frames and reconstructs the pixel/line position.
module vga_sync_monitor
   import vga_sync_monitor_pkg::*;
#(
   parameter int unsigned CLK_PER_PIX = VGA_CLK_PER_PIX,
   parameter int unsigned H_TOTAL     = VGA_H_TOTAL,
   parameter int unsigned H_SYNC      = VGA_H_SYNC,
   parameter int unsigned V_TOTAL     = VGA_V_TOTAL,
   parameter int unsigned V_SYNC      = VGA_V_SYNC,
   parameter int unsigned LOCK_FRAMES = VGA_LOCK_FRAMES
) (
   input  logic       ClkPort,
   input  logic       Reset_n,
   input  logic       hSync,
   input  logic       vSync,
   output logic       locked,
   output logic [9:0] hCount,
   output logic [9:0] vCount,
   output logic       frame_pulse,
   output logic [7:0] err_count
);

   localparam logic [11:0] LINE_MAX    = 12'hFFF;
   localparam logic [11:0] LINE_CLKS   = 12'(H_TOTAL * CLK_PER_PIX);
   localparam logic [11:0] HSW_CLKS    = 12'(H_SYNC * CLK_PER_PIX);
   localparam logic [9:0]  FRAME_LINES = 10'(V_TOTAL);
   localparam logic [9:0]  VSW_LINES   = 10'(V_SYNC);
   localparam logic [7:0]  LOCK_N      = 8'(LOCK_FRAMES);

   logic h_rise, h_fall, v_rise, v_fall;

   sync_edge_detect u_h_edge (
      .clk_i   (ClkPort),
      .rst_n_i (Reset_n),
      .async_i (hSync),
      .rise_o  (h_rise),
      .fall_o  (h_fall)
   );

   sync_edge_detect u_v_edge (
      .clk_i   (ClkPort),
      .rst_n_i (Reset_n),
      .async_i (vSync),
      .rise_o  (v_rise),
      .fall_o  (v_fall)
   );

   mon_state_e  state_q, state_d;
   logic [11:0] line_cnt_q, line_cnt_d;
   logic [9:0]  lines_q, lines_d;
   logic [9:0]  vsw_q, vsw_d;
   logic [7:0]  good_q, good_d;
   logic [7:0]  err_q, err_d;
   logic        fp_q, fp_d;
   logic        meas_bad;
   logic        err_inc;
   logic [11:0] since_fall;

   // line_cnt_q holds clocks since the last hSync fall, so at the next fall it is the line period.
   always_comb begin
      line_cnt_d = line_cnt_q;
      if (h_fall) begin
         line_cnt_d = 12'd1;
      end else if (line_cnt_q != LINE_MAX) begin
         line_cnt_d = line_cnt_q + 12'd1;
      end

      lines_d = lines_q;
      if (v_fall) begin
         lines_d = {9'd0, h_fall};
      end else if (h_fall && (lines_q != 10'h3FF)) begin
         lines_d = lines_q + 10'd1;
      end

      vsw_d = vsw_q;
      if (v_fall) begin
         vsw_d = {9'd0, h_fall};
      end else if (h_fall && (vsw_q != 10'h3FF)) begin
         vsw_d = vsw_q + 10'd1;
      end
   end

   assign meas_bad = (h_fall && (line_cnt_q != LINE_CLKS))
                   || (line_cnt_q == LINE_MAX)
                   || (h_rise && (line_cnt_q != HSW_CLKS))
                   || (v_rise && (vsw_q != VSW_LINES))
                   || (v_fall && (lines_q != FRAME_LINES));

   // Measurements are only trusted once a frame start has been seen, so SEARCH ignores them.
   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      err_inc = 1'b0;
      fp_d    = 1'b0;
      case (state_q)
         SEARCH: begin
            if (v_fall) begin
               state_d = ACQUIRE;
               good_d  = 8'd0;
            end
         end
         ACQUIRE: begin
            if (meas_bad) begin
               state_d = SEARCH;
            end else if (v_fall) begin
               good_d = good_q + 8'd1;
               if ((good_q + 8'd1) == LOCK_N) begin
                  state_d = LOCKED;
               end
            end
         end
         LOCKED: begin
            if (meas_bad) begin
               state_d = SEARCH;
               err_inc = 1'b1;
            end else if (v_fall) begin
               fp_d = 1'b1;
            end
         end
         default: state_d = SEARCH;
      endcase

      err_d = err_q;
      if (err_inc && (err_q != 8'hFF)) begin
         err_d = err_q + 8'd1;
      end
   end

   always_ff @(posedge ClkPort or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= SEARCH;
         line_cnt_q <= 12'd0;
         lines_q    <= 10'd0;
         vsw_q      <= 10'd0;
         good_q     <= 8'd0;
         err_q      <= 8'd0;
         fp_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         line_cnt_q <= line_cnt_d;
         lines_q    <= lines_d;
         vsw_q      <= vsw_d;
         good_q     <= good_d;
         err_q      <= err_d;
         fp_q       <= fp_d;
      end
   end

   assign since_fall  = h_fall ? 12'd0 : line_cnt_q;
   assign locked      = (state_q == LOCKED);
   assign hCount      = locked ? 10'(32'(since_fall) / CLK_PER_PIX) : 10'd0;
   assign vCount      = (locked && (lines_q != 10'd0)) ? (lines_q - 10'd1) : 10'd0;
   assign frame_pulse = fp_q;
   assign err_count   = err_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Directed bench for vga_sync_monitor using a scaled-down raster so that
// repeated lock/unlock cycles stay short.
module tb_vga_sync_monitor;

   localparam int CPP  = 2;
   localparam int HT   = 8;
   localparam int HS   = 2;
   localparam int VT   = 4;
   localparam int VS   = 1;
   localparam int LF   = 2;
   localparam int LINE = HT * CPP;
   localparam int HSW  = HS * CPP;

   logic       ClkPort = 1'b0;
   logic       Reset_n;
   logic       hSync;
   logic       vSync;
   logic       locked;
   logic [9:0] hCount;
   logic [9:0] vCount;
   logic       frame_pulse;
   logic [7:0] err_count;

   int n_checks = 0;
   int n_fail   = 0;
   int fp_cnt   = 0;
   int fp0      = 0;

   always #5 ClkPort = ~ClkPort;

   always @(negedge ClkPort) begin
      if (frame_pulse) fp_cnt <= fp_cnt + 1;
   end

   vga_sync_monitor #(
      .CLK_PER_PIX (CPP),
      .H_TOTAL     (HT),
      .H_SYNC      (HS),
      .V_TOTAL     (VT),
      .V_SYNC      (VS),
      .LOCK_FRAMES (LF)
   ) dut (
      .ClkPort     (ClkPort),
      .Reset_n     (Reset_n),
      .hSync       (hSync),
      .vSync       (vSync),
      .locked      (locked),
      .hCount      (hCount),
      .vCount      (vCount),
      .frame_pulse (frame_pulse),
      .err_count   (err_count)
   );

   // One clock of input levels; returns 1 time unit after the capturing edge.
   task automatic tick(input logic h, input logic v);
      hSync = h;
      vSync = v;
      @(posedge ClkPort);
      #1;
   endtask

   task automatic send_part(input int idx, input int c_from, input int c_to,
                            input int hsw = HSW, input int vsl = VS);
      for (int c = c_from; c < c_to; c++) begin
         tick((c < hsw) ? 1'b0 : 1'b1, (idx < vsl) ? 1'b0 : 1'b1);
      end
   endtask

   // kind: 0 good, 1 line 1 stretched, 2 line 1 hSync too wide, 3 vSync too wide
   task automatic send_frame(input int kind);
      for (int l = 0; l < VT; l++) begin
         send_part(l, 0, (kind == 1 && l == 1) ? LINE + 4 : LINE,
                   (kind == 2 && l == 1) ? HSW + 2 : HSW,
                   (kind == 3) ? VS + 1 : VS);
      end
   endtask

   task automatic test_reset();
      Reset_n = 1'b1;
      hSync   = 1'b1;
      vSync   = 1'b1;
      #2 Reset_n = 1'b0;
      repeat (3) @(posedge ClkPort);
      #1;
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rst_locked: got %0b want 0", locked); end
      n_checks++; if (hCount !== 10'd0) begin n_fail++; $display("FAIL rst_hcount: got %0d want 0", hCount); end
      n_checks++; if (vCount !== 10'd0) begin n_fail++; $display("FAIL rst_vcount: got %0d want 0", vCount); end
      n_checks++; if (frame_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_fp: got %0b want 0", frame_pulse); end
      n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL rst_err: got %0d want 0", err_count); end
      Reset_n = 1'b1;
      repeat (3) tick(1'b1, 1'b1);
   endtask

   task automatic test_lock_and_position();
      send_frame(0);
      send_frame(0);
      send_part(0, 0, 2);
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_early: got %0b want 0", locked); end
      send_part(0, 2, 3);
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_entry: got %0b want 1", locked); end
      n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL lock_err: got %0d want 0", err_count); end
      fp0 = fp_cnt;
      send_part(0, 3, LINE);
      send_part(1, 0, 15);
      n_checks++; if (hCount !== 10'd6) begin n_fail++; $display("FAIL pos_mid_h: got %0d want 6", hCount); end
      n_checks++; if (vCount !== 10'd1) begin n_fail++; $display("FAIL pos_mid_v: got %0d want 1", vCount); end
      send_part(1, 15, LINE);
      send_part(2, 0, LINE);
      n_checks++; if (hCount !== 10'(HT - 1)) begin n_fail++; $display("FAIL pos_end_h: got %0d want %0d", hCount, HT - 1); end
      n_checks++; if (vCount !== 10'd2) begin n_fail++; $display("FAIL pos_end_v: got %0d want 2", vCount); end
      send_part(3, 0, 3);
      n_checks++; if (hCount !== 10'd0) begin n_fail++; $display("FAIL pos_start_h: got %0d want 0", hCount); end
      n_checks++; if (vCount !== 10'(VT - 1)) begin n_fail++; $display("FAIL pos_start_v: got %0d want %0d", vCount, VT - 1); end
      send_part(3, 3, LINE);
      send_frame(0);
      send_part(0, 0, 4);
      n_checks++; if (fp_cnt - fp0 !== 2) begin n_fail++; $display("FAIL frame_pulses: got %0d want 2", fp_cnt - fp0); end
      n_checks++; if (hCount !== 10'd1) begin n_fail++; $display("FAIL pos_f5_h: got %0d want 1", hCount); end
      n_checks++; if (vCount !== 10'd0) begin n_fail++; $display("FAIL pos_f5_v: got %0d want 0", vCount); end
   endtask

   task automatic test_stretch();
      send_part(0, 4, LINE);
      send_part(1, 0, LINE + 4);
      send_part(2, 0, 2);
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL stretch_pre: got %0b want 1", locked); end
      send_part(2, 2, 3);
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL stretch_drop: got %0b want 0", locked); end
      n_checks++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL stretch_err: got %0d want 1", err_count); end
      n_checks++; if (hCount !== 10'd0 || vCount !== 10'd0) begin n_fail++; $display("FAIL stretch_cnt: got %0d/%0d want 0/0", hCount, vCount); end
      send_part(2, 3, LINE);
      send_part(3, 0, LINE);
      send_frame(0);
      send_frame(0);
      send_part(0, 0, 2);
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL relock_early: got %0b want 0", locked); end
      send_part(0, 2, 3);
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL relock: got %0b want 1", locked); end
      n_checks++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL relock_err: got %0d want 1", err_count); end
   endtask

   task automatic test_timeout();
      send_part(0, 3, LINE);
      send_part(1, 0, 4);
      repeat (4093) tick(1'b1, 1'b1);
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL timeout_pre: got %0b want 1", locked); end
      tick(1'b1, 1'b1);
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL timeout_drop: got %0b want 0", locked); end
      n_checks++; if (err_count !== 8'd2) begin n_fail++; $display("FAIL timeout_err: got %0d want 2", err_count); end
      n_checks++; if (hCount !== 10'd0 || vCount !== 10'd0) begin n_fail++; $display("FAIL timeout_cnt: got %0d/%0d want 0/0", hCount, vCount); end
      repeat (5000 - 4094) tick(1'b1, 1'b1);
      n_checks++; if (locked !== 1'b0 || err_count !== 8'd2) begin n_fail++; $display("FAIL timeout_hold: got %0b/%0d want 0/2", locked, err_count); end
   endtask

   task automatic lose_lock(input int n);
      for (int i = 0; i < n; i++) begin
         send_frame(0);
         send_frame(0);
         send_frame(1 + (i % 3));
      end
   endtask

   task automatic test_saturate();
      lose_lock(252);
      n_checks++; if (err_count !== 8'd254) begin n_fail++; $display("FAIL sat_254: got %0d want 254", err_count); end
      lose_lock(1);
      n_checks++; if (err_count !== 8'd255) begin n_fail++; $display("FAIL sat_255: got %0d want 255", err_count); end
      lose_lock(1);
      n_checks++; if (err_count !== 8'd255) begin n_fail++; $display("FAIL sat_hold: got %0d want 255", err_count); end
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL sat_locked: got %0b want 0", locked); end
   endtask

   task automatic test_reset_midframe();
      send_frame(0);
      send_frame(0);
      send_frame(0);
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL mid_prelock: got %0b want 1", locked); end
      send_part(0, 0, LINE);
      send_part(1, 0, 6);
      Reset_n = 1'b0;
      #1;
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL mid_locked: got %0b want 0", locked); end
      n_checks++; if (hCount !== 10'd0 || vCount !== 10'd0) begin n_fail++; $display("FAIL mid_cnt: got %0d/%0d want 0/0", hCount, vCount); end
      n_checks++; if (frame_pulse !== 1'b0) begin n_fail++; $display("FAIL mid_fp: got %0b want 0", frame_pulse); end
      n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL mid_err: got %0d want 0", err_count); end
      send_part(1, 6, LINE);
      Reset_n = 1'b1;
      send_part(2, 0, LINE);
      send_part(3, 0, LINE);
      send_frame(0);
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL mid_relock_t: got %0b want 0", locked); end
      send_frame(0);
      send_part(0, 0, 2);
      n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL mid_relock_early: got %0b want 0", locked); end
      send_part(0, 2, 3);
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL mid_relock: got %0b want 1", locked); end
      n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL mid_relock_err: got %0d want 0", err_count); end
   endtask

   initial begin
      test_reset();
      test_lock_and_position();
      test_stretch();
      test_timeout();
      test_saturate();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
